// File: rtl/openddr_pkg.sv
// rtl/openddr_pkg.sv - shared OpenDDR types and timing defaults for the refresh scheduler
package openddr_pkg;

  parameter int tREFI            = 3120;
  parameter int tRFC             = 208;
  parameter int REF_MAX_POSTPONE = 8;

  typedef enum logic [1:0] {
    REF_IDLE,
    REF_REQ,
    REF_RFC
  } ref_state_t;

endpackage

// File: rtl/ddr_refresh_ctrl_if.sv
// rtl/ddr_refresh_ctrl_if.sv - refresh scheduler <-> command scheduler handshake bundle
interface ddr_refresh_ctrl_if #(
  parameter int MAX_POSTPONE = 8
);
  localparam int PW = $clog2(MAX_POSTPONE + 1);

  logic          init_done;
  logic          banks_idle;
  logic          sched_idle;
  logic          ref_ack;
  logic          ref_req;
  logic          ref_urgent;
  logic          prea_req;
  logic          ref_busy;
  logic [PW-1:0] pending;
  logic          err_overflow;

  modport master (
    output init_done, banks_idle, sched_idle, ref_ack,
    input  ref_req, ref_urgent, prea_req, ref_busy, pending, err_overflow
  );

  modport slave (
    input  init_done, banks_idle, sched_idle, ref_ack,
    output ref_req, ref_urgent, prea_req, ref_busy, pending, err_overflow
  );
endinterface

// File: rtl/ddr_ref_interval_timer.sv
// rtl/ddr_ref_interval_timer.sv - reloadable down-counter emitting a one-cycle tick every PERIOD enabled cycles
module ddr_ref_interval_timer #(
  parameter int PERIOD = 3120
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int             W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0]   RELOAD = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Disabled means parked at the reload value, so re-enabling restarts a full interval.
  always_comb begin
    cnt_d = RELOAD;
    if (en_i && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
  end

  assign tick_o = en_i && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ddr_refresh_ctrl.sv
// rtl/ddr_refresh_ctrl.sv - tREFI/tRFC refresh scheduler with postpone tracking and urgent escalation
// Optional refresh pull-in when idle: define OPENDDR_REF_PULLIN_EN.
module ddr_refresh_ctrl
  import openddr_pkg::*;
#(
  parameter int REFI          = tREFI,
  parameter int RFC           = tRFC,
  parameter int MAX_POSTPONE  = REF_MAX_POSTPONE,
  parameter int URGENT_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst,
  ddr_refresh_ctrl_if.slave  bus
);
  localparam int            PW       = $clog2(MAX_POSTPONE + 1);
  localparam int            RW       = $clog2(RFC);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_POSTPONE);
  localparam logic [PW-1:0] THRESH   = PW'(URGENT_THRESH);
  localparam logic [RW-1:0] RFC_LOAD = RW'(RFC - 1);

  ref_state_t    state_q, state_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [RW-1:0] rfc_q, rfc_d;
  logic          err_q, err_d;
  logic          prea_q, prea_d;
  logic          tick;
  logic          ack_ok;

  ddr_ref_interval_timer #(.PERIOD(REFI)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.init_done),
    .tick_o (tick)
  );

  assign ack_ok = (state_q == REF_REQ) && bus.ref_ack && bus.banks_idle;

`ifdef OPENDDR_REF_PULLIN_EN
  logic [PW-1:0] pulled_q, pulled_d;
`else
  logic unused_sched_idle;
  assign unused_sched_idle = bus.sched_idle;
`endif

  // A tick and an accepted ack in the same cycle cancel out.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
`ifdef OPENDDR_REF_PULLIN_EN
    pulled_d  = pulled_q;
`endif
    if (!(tick && ack_ok)) begin
      if (tick) begin
`ifdef OPENDDR_REF_PULLIN_EN
        if (pulled_q != '0)          pulled_d  = pulled_q - 1'b1;
        else if (pending_q == MAX_P) err_d     = 1'b1;
        else                         pending_d = pending_q + 1'b1;
`else
        if (pending_q == MAX_P) err_d     = 1'b1;
        else                    pending_d = pending_q + 1'b1;
`endif
      end else if (ack_ok) begin
        if (pending_q != '0) pending_d = pending_q - 1'b1;
`ifdef OPENDDR_REF_PULLIN_EN
        else if (pulled_q != MAX_P) pulled_d = pulled_q + 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rfc_d   = rfc_q;
    unique case (state_q)
      REF_IDLE: begin
        if (pending_q != '0) state_d = REF_REQ;
`ifdef OPENDDR_REF_PULLIN_EN
        else if (bus.sched_idle && bus.banks_idle && (pulled_q != MAX_P)) state_d = REF_REQ;
`endif
      end
      REF_REQ: begin
        if (ack_ok) begin
          state_d = REF_RFC;
          rfc_d   = RFC_LOAD;
        end
      end
      REF_RFC: begin
        if (rfc_q == '0) state_d = (pending_d != '0) ? REF_REQ : REF_IDLE;
        else             rfc_d   = rfc_q - 1'b1;
      end
      default: state_d = REF_IDLE;
    endcase
    // Registered so prea_req never follows banks_idle combinationally.
    prea_d = (state_d == REF_REQ) && (pending_d >= THRESH) && !bus.banks_idle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REF_IDLE;
      pending_q <= '0;
      rfc_q     <= '0;
      err_q     <= 1'b0;
      prea_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rfc_q     <= rfc_d;
      err_q     <= err_d;
      prea_q    <= prea_d;
    end
  end

`ifdef OPENDDR_REF_PULLIN_EN
  always_ff @(posedge clk) begin
    if (rst) pulled_q <= '0;
    else     pulled_q <= pulled_d;
  end
`endif

  assign bus.ref_req      = (state_q == REF_REQ);
  assign bus.ref_busy     = (state_q == REF_RFC);
  assign bus.ref_urgent   = (state_q == REF_REQ) && (pending_q >= THRESH);
  assign bus.prea_req     = prea_q;
  assign bus.pending      = pending_q;
  assign bus.err_overflow = err_q;
endmodule
